puf_challenge_driver: RTL and testbench
=======================================

Name: puf_challenge_driver

Overview:
Initiator side of the parallel PUF array interface.
- Steps through a programmed range of 8-bit challenges.
- For each challenge: clears the array, enables it, waits for all eight subblocks to report done, then captures the 8-bit response.
- Streams {flag, challenge, response} records to the host over a valid/ready interface.
- Sits between the host/UART logic and the PUF array instance.

Parameters:
ENABLE_MASK, 32'hFFFF_FFFF, value driven on puf_enable during evaluation.
RST_CYCLES, 4, cycles puf_reset is held high before each evaluation (min 1).
TIMEOUT_CYCLES, 65535, max cycles to wait for puf_all_done before forcing capture (min 1).
CNT_W, 16, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a sequence; honoured only in IDLE
chal_base  input  8  first challenge of the sequence
chal_count  input  9  number of challenges, 0..256
busy  output  1  high from accepted start until the cycle after seq_done
seq_done  output  1  one-cycle pulse when the sequence completes
puf_challenge  output  8  challenge driven to the array
puf_enable  output  32  enable vector to the array
puf_reset  output  1  reset to the array
puf_out  input  8  array response bits
puf_all_done  input  1  AND of the array's per-subblock done bits
resp_valid  output  1  response record valid
resp_ready  input  1  host accepts record
resp_data  output  17  [16] timeout flag, [15:8] challenge, [7:0] response

Behaviour:
Clock and reset: one clock (clock); reset is synchronous and active-high.

Reset values:
- busy=0, seq_done=0, resp_valid=0, resp_data=0
- puf_challenge=0, puf_enable=0, puf_reset=1
- state=IDLE

Reset mid-operation:
- Aborts immediately; no partial record is emitted.
- Any held resp_valid drops the cycle after reset is sampled.

States:
- IDLE:
  - puf_reset=1, puf_enable=0.
  - When start=1, latch chal_base into the challenge register and chal_count into the remaining counter.
  - If chal_count=0: pulse seq_done the next cycle and stay in IDLE (busy never rises).
  - Otherwise set busy=1 and go to CLEAR.
- CLEAR:
  - puf_reset=1, puf_enable=0, puf_challenge=current challenge.
  - Stay exactly RST_CYCLES cycles, then go to EVAL.
- EVAL:
  - puf_reset=0, puf_enable=ENABLE_MASK; timeout counter runs from 0.
  - If puf_all_done=1: capture puf_out, flag=0, go to OUTPUT.
  - Else if the counter reaches TIMEOUT_CYCLES-1: capture puf_out, flag=1, go to OUTPUT.
  - If all_done and timeout coincide, all_done wins (flag=0).
- OUTPUT:
  - puf_enable=0, puf_reset=1.
  - resp_valid=1; resp_data holds stable until resp_valid && resp_ready.
  - On handshake: decrement remaining and increment the challenge (mod 256, so 8'hFF wraps to 8'h00).
  - If remaining was 1: pulse seq_done, go to IDLE, busy=0 the next cycle.
  - Otherwise go to CLEAR.
- start is ignored while busy.

Latency: start to first EVAL entry = 1 + RST_CYCLES cycles.

Optional Feature:
Macro: PUF_DRV_MAJORITY_EN
- Defined:
  - Each challenge is evaluated three times (CLEAR→EVAL ×3) before OUTPUT.
  - resp_data[7:0] is the bitwise 2-of-3 majority of the three captures.
  - resp_data[16] is the OR of the three timeout flags.
  - The challenge is unchanged across the three passes.
- Undefined: single evaluation per challenge, as above.

Decomposition:
- Package puf_drv_pkg: state enum (IDLE, CLEAR, EVAL, OUTPUT), packed struct for resp_data {timeout, challenge, response}, width constants CHAL_W=8, RESP_W=8.
- Sub-module puf_drv_vote (3-capture bitwise majority register), instantiated only under PUF_DRV_MAJORITY_EN.

Test Plan:
- Bench uses a PUF model that raises all_done N cycles after puf_reset drops and returns response = challenge ^ 8'hA5.
- Single challenge: base=8'h10, count=1, N=5, resp_ready=1 → one record 17'h0_10_B5; seq_done one cycle after the handshake; puf_reset high for exactly RST_CYCLES before each EVAL.
- Wrap: base=8'hFE, count=4 → records with challenges FE, FF, 00, 01 in order; busy high throughout; exactly one seq_done.
- Backpressure: resp_ready low for 10 cycles with a record pending → resp_valid stays high, resp_data stable, no new CLEAR until the handshake.
- Timeout: TIMEOUT_CYCLES=8, model never asserts done, puf_out=8'h3C → record 17'h1_xx_3C after exactly 8 EVAL cycles; sequence continues.
- count=0 → seq_done pulse, busy stays 0, puf_enable never asserted.
- Reset asserted mid-EVAL → next cycle: IDLE, puf_reset=1, resp_valid=0; a new start then runs normally. With PUF_DRV_MAJORITY_EN, captures 8'hF0, 8'hF1, 8'h01 → response 8'hF1.

Source files
------------

// File: rtl/puf_drv_pkg.sv
// Shared types for the PUF challenge driver: FSM states and the response record layout.
package puf_drv_pkg;

  localparam int CHAL_W = 8;
  localparam int RESP_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    EVAL,
    OUTPUT
  } state_t;

  // Bit 16 is the timeout flag, then the challenge, then the captured response.
  typedef struct packed {
    logic              timeout;
    logic [CHAL_W-1:0] challenge;
    logic [RESP_W-1:0] response;
  } resp_rec_t;

endpackage

// File: rtl/puf_challenge_driver_if.sv
// Bundles the PUF array wires and the host response stream; master = driver side.
interface puf_challenge_driver_if;
  import puf_drv_pkg::*;

  logic [CHAL_W-1:0] puf_challenge;
  logic [31:0]       puf_enable;
  logic              puf_reset;
  logic [RESP_W-1:0] puf_out;
  logic              puf_all_done;
  logic              resp_valid;
  logic              resp_ready;
  resp_rec_t         resp_data;

  modport master (
    output puf_challenge, puf_enable, puf_reset, resp_valid, resp_data,
    input  puf_out, puf_all_done, resp_ready
  );

  modport slave (
    input  puf_challenge, puf_enable, puf_reset, resp_valid, resp_data,
    output puf_out, puf_all_done, resp_ready
  );
endinterface

// File: rtl/puf_drv_vote.sv
// Holds the first two captures of a challenge and votes them against the live third capture.
module puf_drv_vote
  import puf_drv_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [1:0]        pass,
  input  logic [RESP_W-1:0] data,
  input  logic              flag,
  output logic [RESP_W-1:0] maj,
  output logic              flag_or
);

  logic [RESP_W-1:0] cap0_reg, cap1_reg;
  logic              flag0_reg, flag1_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      cap0_reg  <= '0;
      cap1_reg  <= '0;
      flag0_reg <= 1'b0;
      flag1_reg <= 1'b0;
    end else if (cap_en) begin
      if (pass == 2'd0) begin
        cap0_reg  <= data;
        flag0_reg <= flag;
      end else if (pass == 2'd1) begin
        cap1_reg  <= data;
        flag1_reg <= flag;
      end
    end
  end

  for (genvar gi = 0; gi < RESP_W; gi++) begin : g_vote
    assign maj[gi] = (cap0_reg[gi] & cap1_reg[gi]) | (cap0_reg[gi] & data[gi]) |
                     (cap1_reg[gi] & data[gi]);
  end

  assign flag_or = flag0_reg | flag1_reg | flag;

endmodule

// File: rtl/puf_challenge_driver.sv
// Sweeps a challenge range over the PUF array and streams {flag, challenge, response} records.
// Define PUF_DRV_MAJORITY_EN to evaluate each challenge three times and report the bitwise majority.
module puf_challenge_driver
  import puf_drv_pkg::*;
#(
  parameter logic [31:0] ENABLE_MASK    = 32'hFFFF_FFFF,
  parameter int          RST_CYCLES     = 4,
  parameter int          TIMEOUT_CYCLES = 65535,
  parameter int          CNT_W          = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CHAL_W-1:0]      chal_base,
  input  logic [8:0]             chal_count,
  output logic                   busy,
  output logic                   seq_done,
  puf_challenge_driver_if.master bus
);

  state_t            state_reg;
  logic [CHAL_W-1:0] chal_reg;
  logic [8:0]        remain_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy_reg, seq_done_reg, resp_valid_reg, puf_reset_reg;
  logic [31:0]       enable_reg;
  resp_rec_t         resp_data_reg;

  logic              eval_end, cap_flag, last_pass, rec_flag;
  logic [RESP_W-1:0] rec_resp;

  // all_done takes priority over a coinciding timeout, so the flag is simply !all_done.
  assign eval_end = (state_reg == EVAL) &&
                    (bus.puf_all_done || (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)));
  assign cap_flag = ~bus.puf_all_done;

`ifdef PUF_DRV_MAJORITY_EN
  logic [1:0] pass_reg;

  puf_drv_vote u_vote (
    .clock   (clock),
    .reset   (reset),
    .cap_en  (eval_end),
    .pass    (pass_reg),
    .data    (bus.puf_out),
    .flag    (cap_flag),
    .maj     (rec_resp),
    .flag_or (rec_flag)
  );
  assign last_pass = (pass_reg == 2'd2);
`else
  assign last_pass = 1'b1;
  assign rec_resp  = bus.puf_out;
  assign rec_flag  = cap_flag;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      chal_reg       <= '0;
      remain_reg     <= '0;
      cnt_reg        <= '0;
      busy_reg       <= 1'b0;
      seq_done_reg   <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      puf_reset_reg  <= 1'b1;
      enable_reg     <= '0;
`ifdef PUF_DRV_MAJORITY_EN
      pass_reg       <= 2'd0;
`endif
    end else begin
      seq_done_reg <= 1'b0;
      if (seq_done_reg) busy_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !busy_reg) begin
            chal_reg   <= chal_base;
            remain_reg <= chal_count;
            cnt_reg    <= '0;
`ifdef PUF_DRV_MAJORITY_EN
            pass_reg   <= 2'd0;
`endif
            if (chal_count == 9'd0) begin
              seq_done_reg <= 1'b1;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= CLEAR;
            end
          end
        end
        CLEAR: begin
          if (cnt_reg == CNT_W'(RST_CYCLES - 1)) begin
            cnt_reg       <= '0;
            puf_reset_reg <= 1'b0;
            enable_reg    <= ENABLE_MASK;
            state_reg     <= EVAL;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        EVAL: begin
          if (eval_end) begin
            cnt_reg       <= '0;
            puf_reset_reg <= 1'b1;
            enable_reg    <= '0;
            if (last_pass) begin
              resp_valid_reg <= 1'b1;
              resp_data_reg  <= '{timeout: rec_flag, challenge: chal_reg, response: rec_resp};
              state_reg      <= OUTPUT;
`ifdef PUF_DRV_MAJORITY_EN
              pass_reg       <= 2'd0;
`endif
            end else begin
`ifdef PUF_DRV_MAJORITY_EN
              pass_reg  <= pass_reg + 2'd1;
`endif
              state_reg <= CLEAR;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.resp_ready) begin
            resp_valid_reg <= 1'b0;
            remain_reg     <= remain_reg - 9'd1;
            chal_reg       <= chal_reg + 1'b1;
            if (remain_reg == 9'd1) begin
              seq_done_reg <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              state_reg <= CLEAR;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy              = busy_reg;
  assign seq_done          = seq_done_reg;
  assign bus.puf_challenge = chal_reg;
  assign bus.puf_enable    = enable_reg;
  assign bus.puf_reset     = puf_reset_reg;
  assign bus.resp_valid    = resp_valid_reg;
  assign bus.resp_data     = resp_data_reg;

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Directed bench for puf_challenge_driver with a behavioural PUF array and a record scoreboard.
module tb_puf_challenge_driver;
  import puf_drv_pkg::*;

  localparam int          RST_CYCLES = 4;
  localparam int          TIMEOUT    = 8;
  localparam logic [31:0] MASK       = 32'hFFFF_FFFF;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] chal_base = 8'h00;
  logic [8:0] chal_count = 9'd0;
  logic       busy, seq_done;

  puf_challenge_driver_if bus ();

  puf_challenge_driver #(
    .ENABLE_MASK    (MASK),
    .RST_CYCLES     (RST_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .chal_base  (chal_base),
    .chal_count (chal_count),
    .busy       (busy),
    .seq_done   (seq_done),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  // PUF array model: done N cycles into evaluation, response = challenge ^ A5 unless overridden.
  int         done_n = 5;
  bit         never_done = 1'b0;
  bit         force_out = 1'b0;
  logic [7:0] force_val = 8'h00;
  bit         use_tbl = 1'b0;
  bit         tbl_clr = 1'b0;
  logic [7:0] tbl [3] = '{8'hF0, 8'hF1, 8'h01};
  int         eval_cyc = 0;
  int         eval_idx = 0;
  logic       prev_rst = 1'b1;
  int         cyc = 0;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    prev_rst <= bus.puf_reset;
    eval_cyc <= bus.puf_reset ? 0 : eval_cyc + 1;
    if (tbl_clr) eval_idx <= 0;
    else if (bus.puf_reset && !prev_rst) eval_idx <= eval_idx + 1;
  end

  assign bus.puf_all_done = !bus.puf_reset && !never_done && (eval_cyc >= done_n);
  assign bus.puf_out = use_tbl ? tbl[eval_idx % 3] :
                       force_out ? force_val : (bus.puf_challenge ^ 8'hA5);

  logic [16:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int hs_cyc = -10;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit flag, input logic [7:0] ch, input logic [7:0] r);
    exp_q.push_back({flag, ch, r});
  endtask

  task automatic start_seq(input logic [7:0] base, input logic [8:0] count);
    chal_base  = base;
    chal_count = count;
    start      = 1'b1;
    @(negedge clock);
    start      = 1'b0;
  endtask

  // Runs until seq_done, measuring the first CLEAR and EVAL lengths and enable/reset consistency.
  task automatic wait_done(output bit seen, output int busy_low, output int rst_run,
                           output int eval_len, output int en_bad, output int done_cyc);
    int phase = 0;
    seen = 1'b0; busy_low = 0; rst_run = 0; eval_len = 0; en_bad = 0; done_cyc = -1;
    for (int n = 0; n < 3000; n++) begin
      if (seq_done) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (!busy) busy_low++;
      if (bus.puf_reset ? (bus.puf_enable !== 32'h0) : (bus.puf_enable !== MASK)) en_bad++;
      if (phase == 0) begin
        if (bus.puf_reset) rst_run++;
        else begin phase = 1; eval_len = 1; end
      end else if (phase == 1) begin
        if (!bus.puf_reset) eval_len++;
        else phase = 2;
      end
      @(negedge clock);
    end
  endtask

  // Scoreboard: a record is consumed on every valid/ready handshake.
  initial begin : monitor
    logic [16:0] obs;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && bus.resp_valid && bus.resp_ready) begin
        hs_cyc = cyc;
        obs = bus.resp_data;
        checks++;
        assert (exp_q.size() > 0)
        else begin
          errors++;
          $error("FAIL record_unexpected observed=%0h expected=none", obs);
        end
        if (exp_q.size() > 0) chk("record", 32'(obs), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin : main
    bit         seen;
    int         busy_low, rst_run, eval_len, en_bad, done_cyc, extra, bad;
    logic [16:0] held_data;
    logic [7:0]  held_chal;

    bus.resp_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_seq_done", seq_done, 0);
    chk("reset_resp_valid", bus.resp_valid, 0);
    chk("reset_resp_data", 32'(bus.resp_data), 0);
    chk("reset_puf_challenge", bus.puf_challenge, 0);
    chk("reset_puf_enable", bus.puf_enable, 0);
    chk("reset_puf_reset", bus.puf_reset, 1);
    reset = 1'b0;
    @(negedge clock);

    // Single challenge
    push(1'b0, 8'h10, 8'hB5);
    start_seq(8'h10, 9'd1);
    wait_done(seen, busy_low, rst_run, eval_len, en_bad, done_cyc);
    chk("single_seq_done_seen", seen, 1);
    chk("single_clear_len", rst_run, RST_CYCLES);
    chk("single_eval_len", eval_len, done_n + 1);
    chk("single_enable", en_bad, 0);
    chk("single_busy_high", busy_low, 0);
    chk("single_done_after_hs", done_cyc, hs_cyc + 1);
    @(negedge clock);
    chk("single_busy_drop", busy, 0);
    chk("single_done_pulse", seq_done, 0);

    // Wrap across 8'hFF
    push(1'b0, 8'hFE, 8'h5B);
    push(1'b0, 8'hFF, 8'h5A);
    push(1'b0, 8'h00, 8'hA5);
    push(1'b0, 8'h01, 8'hA4);
    start_seq(8'hFE, 9'd4);
    wait_done(seen, busy_low, rst_run, eval_len, en_bad, done_cyc);
    chk("wrap_seq_done_seen", seen, 1);
    chk("wrap_busy_high", busy_low, 0);
    chk("wrap_enable", en_bad, 0);
    extra = 0;
    repeat (4) begin
      @(negedge clock);
      if (seq_done) extra++;
    end
    chk("wrap_single_seq_done", extra, 0);
    chk("wrap_queue_drained", exp_q.size(), 0);

    // Backpressure
    bus.resp_ready = 1'b0;
    push(1'b0, 8'h20, 8'h85);
    push(1'b0, 8'h21, 8'h84);
    start_seq(8'h20, 9'd2);
    for (int n = 0; n < 300 && !bus.resp_valid; n++) @(negedge clock);
    chk("bp_valid_seen", bus.resp_valid, 1);
    held_data = bus.resp_data;
    held_chal = bus.puf_challenge;
    bad = 0;
    repeat (10) begin
      @(negedge clock);
      if (!bus.resp_valid || bus.resp_data !== held_data || !bus.puf_reset ||
          bus.puf_enable !== 32'h0 || bus.puf_challenge !== held_chal) bad++;
    end
    chk("bp_hold_stable", bad, 0);
    chk("bp_held_record", 32'(held_data), 32'h0_20_85);
    bus.resp_ready = 1'b1;
    wait_done(seen, busy_low, rst_run, eval_len, en_bad, done_cyc);
    chk("bp_seq_done_seen", seen, 1);
    @(negedge clock);

    // Timeout: array never reports done
    never_done = 1'b1;
    force_out  = 1'b1;
    force_val  = 8'h3C;
    push(1'b1, 8'h40, 8'h3C);
    push(1'b1, 8'h41, 8'h3C);
    start_seq(8'h40, 9'd2);
    wait_done(seen, busy_low, rst_run, eval_len, en_bad, done_cyc);
    chk("timeout_seq_done_seen", seen, 1);
    chk("timeout_eval_len", eval_len, TIMEOUT);
    chk("timeout_enable", en_bad, 0);
    never_done = 1'b0;
    force_out  = 1'b0;
    @(negedge clock);

    // Empty sequence
    start_seq(8'h77, 9'd0);
    chk("count0_seq_done", seq_done, 1);
    chk("count0_busy", busy, 0);
    bad = 0;
    repeat (4) begin
      @(negedge clock);
      if (busy || seq_done || bus.puf_enable !== 32'h0 || !bus.puf_reset) bad++;
    end
    chk("count0_idle_after", bad, 0);

    // Reset during evaluation aborts without emitting a record
    start_seq(8'h50, 9'd3);
    for (int n = 0; n < 100 && bus.puf_reset; n++) @(negedge clock);
    chk("abort_in_eval", bus.puf_reset, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_puf_reset", bus.puf_reset, 1);
    chk("abort_resp_valid", bus.resp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_enable", bus.puf_enable, 0);
    tbl_clr = 1'b1;
    @(negedge clock);
    tbl_clr = 1'b0;
    use_tbl = 1'b1;
`ifdef PUF_DRV_MAJORITY_EN
    push(1'b0, 8'h60, 8'hF1);
`else
    push(1'b0, 8'h60, 8'hF0);
`endif
    start_seq(8'h60, 9'd1);
    wait_done(seen, busy_low, rst_run, eval_len, en_bad, done_cyc);
    chk("restart_seq_done_seen", seen, 1);
    chk("restart_clear_len", rst_run, RST_CYCLES);
    use_tbl = 1'b0;

    repeat (3) @(negedge clock);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
